// File: rtl/switch_pkg.sv
// Shared definitions for the 3-port switch egress path.
// Register map and the per-entry FIFO payload.
package switch_pkg;
  localparam int NUM_PORTS = 3;
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_DATA0  = 3'd1;
  localparam logic [2:0] ADDR_LAST   = 3'd7;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } egr_entry_t;
endpackage

// File: rtl/egress_port_fifo.sv
// Per-port circular buffer of bytes tagged with end-of-packet.
// Tracks occupancy and the number of complete packets held.
module egress_port_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  input  egr_entry_t push_entry,
  output logic       ready,
  input  logic       pop,
  output egr_entry_t pop_entry,
  output logic       empty,
  output logic       pkt_avail
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  egr_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt_cnt;
  logic do_push;
  logic do_pop;
  logic pkt_inc;
  logic pkt_dec;

  // Ready comes from the registered count only, so a pop never
  // opens room for a push in the same cycle.
  assign ready     = (count != CW'(DEPTH));
  assign empty     = (count == '0);
  assign pkt_avail = (pkt_cnt != '0);
  assign pop_entry = mem[rd_ptr];
  assign do_push   = push_valid && ready;
  assign do_pop    = pop && !empty;
  assign pkt_inc   = do_push && push_entry.last;
  assign pkt_dec   = do_pop && pop_entry.last;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) count <= count + CW'(1);
      if (!do_push && do_pop) count <= count - CW'(1);
      if (pkt_inc && !pkt_dec) pkt_cnt <= pkt_cnt + CW'(1);
      if (!pkt_inc && pkt_dec) pkt_cnt <= pkt_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/egress_reader.sv
// Avalon-MM read slave draining per-port egress FIFOs.
// Holds address decode, sticky underflow, last_seen, readdata and irq.
module egress_reader
  import switch_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             chipselect,
  input  logic                             read,
  input  logic                             write,
  input  logic [2:0]                       address,
  input  logic [DATA_W-1:0]                writedata,
  output logic [DATA_W-1:0]                readdata,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] egr_data,
  input  logic [NUM_PORTS-1:0]             egr_valid,
  input  logic [NUM_PORTS-1:0]             egr_last,
  output logic [NUM_PORTS-1:0]             egr_ready,
  output logic                             irq
);
  logic rd;
  logic wr;
  logic is_status;
  logic is_last;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] pkt_avail;
  logic [NUM_PORTS-1:0] underflow;
  logic [NUM_PORTS-1:0] last_seen;
  logic [NUM_PORTS-1:0] uf_set;
  logic [NUM_PORTS-1:0] uf_clr;
  logic [DATA_W-1:0]    rd_next;
  egr_entry_t [NUM_PORTS-1:0] pop_entry;

  assign rd        = chipselect && read;
  assign wr        = chipselect && write;
  assign is_status = (address == ADDR_STATUS);
  assign is_last   = (address == ADDR_LAST);
  assign uf_set    = pop & empty;
  assign uf_clr    = (wr && is_status) ? writedata[5:3] : '0;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    egr_entry_t push_entry;
    assign pop[p] = rd && (address == 3'(ADDR_DATA0 + p));
    assign push_entry.last = egr_last[p];
    assign push_entry.data = 8'(egr_data[p]);

    egress_port_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (egr_valid[p]),
      .push_entry (push_entry),
      .ready      (egr_ready[p]),
      .pop        (pop[p]),
      .pop_entry  (pop_entry[p]),
      .empty      (empty[p]),
      .pkt_avail  (pkt_avail[p])
    );
  end

  always_comb begin
    rd_next = '0;
    unique case (1'b1)
      is_status: rd_next = DATA_W'({underflow, pkt_avail});
      is_last:   rd_next = DATA_W'(last_seen);
      default: begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (pop[p] && !empty[p]) rd_next = DATA_W'(pop_entry[p].data);
        end
      end
    endcase
  end

  // A new underflow beats a same-cycle W1C of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata  <= '0;
      underflow <= '0;
      last_seen <= '0;
      irq       <= 1'b0;
    end else begin
      if (rd) readdata <= rd_next;
      underflow <= (underflow & ~uf_clr) | uf_set;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pop[p] && !empty[p]) last_seen[p] <= pop_entry[p].last;
      end
      irq <= |pkt_avail;
    end
  end
endmodule

// File: tb/tb_egress_reader.sv
// Randomized bench for egress_reader against a queue-based model.
// Directed scenarios first, then random traffic with sporadic resets.
module tb_egress_reader;
  localparam int DEPTH = 16;

  typedef struct {
    logic       last;
    logic [7:0] data;
  } ent_t;

  logic            clk;
  logic            reset;
  logic            chipselect;
  logic            read;
  logic            write;
  logic [2:0]      address;
  logic [7:0]      writedata;
  logic [7:0]      readdata;
  logic [2:0][7:0] egr_data;
  logic [2:0]      egr_valid;
  logic [2:0]      egr_last;
  logic [2:0]      egr_ready;
  logic            irq;

  int checks;
  int failures;

  ent_t       q [3][$];
  logic [2:0] m_uf;
  logic [2:0] m_ls;
  logic [7:0] m_rd;
  logic       m_irq;

  egress_reader #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .egr_data   (egr_data),
    .egr_valid  (egr_valid),
    .egr_last   (egr_last),
    .egr_ready  (egr_ready),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // A port has a packet available when it holds any entry marked last.
  function automatic logic [2:0] model_avail();
    logic [2:0] r;
    r = '0;
    for (int p = 0; p < 3; p++)
      foreach (q[p][i]) if (q[p][i].last) r[p] = 1'b1;
    return r;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < 3; p++) q[p].delete();
    m_uf = '0;
    m_ls = '0;
    m_rd = '0;
    m_irq = 1'b0;
  endtask

  task automatic step(input logic c, input logic r, input logic w,
                      input logic [2:0] a, input logic [7:0] wd,
                      input logic [2:0] v, input logic [2:0] l,
                      input logic [23:0] d);
    logic [2:0] pa;
    logic [2:0] rdy;
    logic [2:0] set;
    logic [2:0] clr;
    int         p;
    ent_t       e;
    chipselect = c;
    read = r;
    write = w;
    address = a;
    writedata = wd;
    egr_valid = v;
    egr_last = l;
    egr_data = d;
    #1;
    pa = model_avail();
    for (int i = 0; i < 3; i++) rdy[i] = (q[i].size() != DEPTH);
    chk("egr_ready", {29'd0, egr_ready}, {29'd0, rdy});
    set = '0;
    clr = (c && w && a == 3'd0) ? wd[5:3] : 3'd0;
    if (c && r) begin
      if (a == 3'd0) m_rd = {2'b00, m_uf, pa};
      else if (a == 3'd7) m_rd = {5'd0, m_ls};
      else if (a >= 3'd1 && a <= 3'd3) begin
        p = int'(a) - 1;
        if (q[p].size() == 0) begin
          m_rd = 8'h00;
          set[p] = 1'b1;
        end else begin
          e = q[p].pop_front();
          m_rd = e.data;
          m_ls[p] = e.last;
        end
      end else m_rd = 8'h00;
    end
    for (int i = 0; i < 3; i++) begin
      if (v[i] && rdy[i]) begin
        e.last = l[i];
        e.data = d[i*8 +: 8];
        q[i].push_back(e);
      end
    end
    m_uf = (m_uf & ~clr) | set;
    m_irq = |pa;
    @(posedge clk);
    #1;
    chk("readdata", {24'd0, readdata}, {24'd0, m_rd});
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic idle();
    step(0, 0, 0, 3'd0, 8'd0, 3'd0, 3'd0, 24'd0);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    step(1, 1, 0, a, 8'd0, 3'd0, 3'd0, 24'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    chipselect = 0;
    read = 0;
    write = 0;
    egr_valid = '0;
    #1;
    model_clear();
    chk("rst_readdata", {24'd0, readdata}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ready", {29'd0, egr_ready}, 32'd7);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    chipselect = 0;
    read = 0;
    write = 0;
    address = '0;
    writedata = '0;
    egr_data = '0;
    egr_valid = '0;
    egr_last = '0;
    reset = 1'b1;
    model_clear();
    #2;
    do_reset();

    // 1: reset state
    rd_reg(3'd0);
    chk("t1_status", {24'd0, readdata}, 32'h00);

    // 2: one packet on port 0
    step(0, 0, 0, 3'd0, 8'd0, 3'b001, 3'b000, 24'h0000A1);
    step(0, 0, 0, 3'd0, 8'd0, 3'b001, 3'b001, 24'h0000B2);
    idle();
    chk("t2_irq_hi", {31'd0, irq}, 32'd1);
    rd_reg(3'd1);
    chk("t2_pop0", {24'd0, readdata}, 32'hA1);
    rd_reg(3'd1);
    chk("t2_pop1", {24'd0, readdata}, 32'hB2);
    idle();
    chk("t2_irq_lo", {31'd0, irq}, 32'd0);
    rd_reg(3'd7);
    chk("t2_last", {24'd0, readdata}, 32'h01);

    // 3: underflow then W1C
    rd_reg(3'd2);
    chk("t3_empty", {24'd0, readdata}, 32'h00);
    rd_reg(3'd0);
    chk("t3_uf_set", {31'd0, readdata[4]}, 32'd1);
    step(1, 0, 1, 3'd0, 8'h10, 3'd0, 3'd0, 24'd0);
    rd_reg(3'd0);
    chk("t3_uf_clr", {31'd0, readdata[4]}, 32'd0);

    // 4: fill port 2, overflow byte dropped
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, 0, 3'd0, 8'd0, 3'b100, (i == DEPTH - 1) ? 3'b100 : 3'b000,
           {8'(i + 8'h40), 16'd0});
    chk("t4_full", {31'd0, egr_ready[2]}, 32'd0);
    step(0, 0, 0, 3'd0, 8'd0, 3'b100, 3'b100, 24'hEE0000);
    rd_reg(3'd3);
    chk("t4_first", {24'd0, readdata}, 32'h40);
    chk("t4_ready", {31'd0, egr_ready[2]}, 32'd1);
    for (int i = 1; i < DEPTH; i++) rd_reg(3'd3);
    chk("t4_tail", {24'd0, readdata}, 32'h4F);

    // 5: pop last byte while pushing another on port 1
    step(0, 0, 0, 3'd0, 8'd0, 3'b010, 3'b010, 24'h005500);
    step(1, 1, 0, 3'd2, 8'd0, 3'b010, 3'b010, 24'h006600);
    chk("t5_pop", {24'd0, readdata}, 32'h55);
    rd_reg(3'd0);
    chk("t5_avail", {31'd0, readdata[1]}, 32'd1);
    rd_reg(3'd2);

    // 6: reset mid-packet
    step(0, 0, 0, 3'd0, 8'd0, 3'b001, 3'b000, 24'h000011);
    step(0, 0, 0, 3'd0, 8'd0, 3'b001, 3'b000, 24'h000022);
    do_reset();
    rd_reg(3'd1);
    chk("t6_pop", {24'd0, readdata}, 32'h00);
    rd_reg(3'd0);
    chk("t6_uf", {24'd0, readdata}, 32'h08);

    // random traffic: fill-heavy phase, then drain-heavy phase
    for (int n = 0; n < 800; n++) begin
      logic [2:0] v;
      logic       r;
      if ($urandom_range(0, 199) == 0) do_reset();
      v = (n < 400) ? 3'($urandom) : 3'($urandom & $urandom & $urandom);
      r = 1'($urandom);
      step($urandom_range(0, 9) != 0, r, !r && ($urandom_range(0, 3) == 0),
           (n < 400) ? 3'($urandom) : 3'($urandom_range(0, 3)),
           8'($urandom), v, 3'($urandom & $urandom), 24'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
